// File: rtl/aud_pkg.sv
// Shared types and constants for the audio recorder/player sequencer.
package aud_pkg;

    localparam int unsigned ADDR_W = 20;
    localparam int unsigned TIME_W = 6;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_REC        = 3'd1,
        S_REC_PAUSE  = 3'd2,
        S_PLAY       = 3'd3,
        S_PLAY_PAUSE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_FAST   = 2'd1,
        MODE_SLOW0  = 2'd2,
        MODE_SLOW1  = 2'd3
    } mode_t;

endpackage

// File: rtl/aud_sec_timer.sv
// Elapsed-seconds counter: CLK_FREQ-cycle tick driving a saturating 6-bit count.
module aud_sec_timer
    import aud_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 12000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    output logic [TIME_W-1:0] o_sec
);

    localparam int unsigned CNT_W = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [TIME_W-1:0] SEC_MAX = '1;

    logic [CNT_W-1:0] cyc;
    logic             wrap_c;

    assign wrap_c = (cyc == CNT_W'(CLK_FREQ - 1));

    // Cycle counter only advances while enabled, so pauses freeze the partial second too.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            cyc   <= '0;
            o_sec <= '0;
        end else if (i_en) begin
            if (wrap_c) begin
                cyc <= '0;
                if (o_sec != SEC_MAX) begin
                    o_sec <= o_sec + TIME_W'(1);
                end
            end else begin
                cyc <= cyc + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/aud_ctrl.sv
// Record/play sequencer: key decode, command pulses, SRAM mux, end address, elapsed time.
// Build option: AUD_CTRL_LOOP_EN makes playback auto-end restart instead of returning to idle.
module aud_ctrl
    import aud_pkg::*;
#(
    parameter int unsigned       CLK_FREQ = 12000000,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_key_rec,
    input  logic              i_key_play,
    input  logic              i_key_pause,
    input  logic              i_key_stop,
    input  logic [2:0]        i_speed,
    input  logic [1:0]        i_mode,
    input  logic [ADDR_W-1:0] i_rec_addr,
    input  logic [ADDR_W-1:0] i_dsp_addr,
    output logic              o_rec_start,
    output logic              o_rec_pause,
    output logic              o_rec_stop,
    output logic              o_dsp_start,
    output logic              o_dsp_pause,
    output logic              o_dsp_stop,
    output logic [2:0]        o_dsp_speed,
    output logic              o_dsp_fast,
    output logic              o_dsp_slow_0,
    output logic              o_dsp_slow_1,
    output logic [ADDR_W-1:0] o_sram_addr,
    output logic              o_sram_we_n,
    output logic [ADDR_W-1:0] o_end_addr,
    output logic [2:0]        o_state,
    output logic [TIME_W-1:0] o_time_sec
);

    state_t state;
    logic   loop_pend;
    logic   rec_full_c;
    logic   play_end_c;
    logic   restart_c;
    logic   idle_go_c;
    logic   time_clr_c;
    logic   time_en_c;
    mode_t  mode_c;

    assign mode_c     = mode_t'(i_mode);
    assign rec_full_c = (state == S_REC) && (i_rec_addr == ADDR_MAX);
    // While a loop restart is pending the DSP address is still stale, so ignore it.
    assign play_end_c = (state == S_PLAY) && (i_dsp_addr > o_end_addr) && !loop_pend;
    assign restart_c  = loop_pend && !i_key_stop;
    assign idle_go_c  = (state == S_IDLE) && (i_key_rec || (i_key_play && (o_end_addr != '0)));
    assign time_clr_c = idle_go_c || restart_c;
    assign time_en_c  = (state == S_REC) || (state == S_PLAY);

    assign o_state     = state;
    assign o_sram_addr = ((state == S_REC) || (state == S_REC_PAUSE)) ? i_rec_addr : i_dsp_addr;
    assign o_sram_we_n = (state != S_REC);

    // Sequencer: highest-priority legal key wins; auto-stops behave as stop.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= S_IDLE;
            loop_pend    <= 1'b0;
            o_rec_start  <= 1'b0;
            o_rec_pause  <= 1'b0;
            o_rec_stop   <= 1'b0;
            o_dsp_start  <= 1'b0;
            o_dsp_pause  <= 1'b0;
            o_dsp_stop   <= 1'b0;
            o_dsp_speed  <= '0;
            o_dsp_fast   <= 1'b0;
            o_dsp_slow_0 <= 1'b0;
            o_dsp_slow_1 <= 1'b0;
            o_end_addr   <= '0;
        end else begin
            o_rec_start <= 1'b0;
            o_rec_pause <= 1'b0;
            o_rec_stop  <= 1'b0;
            o_dsp_start <= 1'b0;
            o_dsp_pause <= 1'b0;
            o_dsp_stop  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (i_key_play && (o_end_addr != '0)) begin
                        state        <= S_PLAY;
                        o_dsp_start  <= 1'b1;
                        o_dsp_speed  <= i_speed;
                        o_dsp_fast   <= (mode_c == MODE_FAST);
                        o_dsp_slow_0 <= (mode_c == MODE_SLOW0);
                        o_dsp_slow_1 <= (mode_c == MODE_SLOW1);
                    end else if (i_key_rec) begin
                        state       <= S_REC;
                        o_rec_start <= 1'b1;
                    end
                end
                S_REC, S_REC_PAUSE: begin
                    if (i_key_stop || rec_full_c) begin
                        state      <= S_IDLE;
                        o_rec_stop <= 1'b1;
                        o_end_addr <= i_rec_addr;
                    end else if (i_key_pause && (state == S_REC)) begin
                        state       <= S_REC_PAUSE;
                        o_rec_pause <= 1'b1;
                    end else if (i_key_rec && (state == S_REC_PAUSE)) begin
                        state       <= S_REC;
                        o_rec_start <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (i_key_stop) begin
                        state      <= S_IDLE;
                        loop_pend  <= 1'b0;
                        o_dsp_stop <= 1'b1;
                    end else if (restart_c) begin
                        loop_pend   <= 1'b0;
                        o_dsp_start <= 1'b1;
                    end else if (play_end_c) begin
                        o_dsp_stop <= 1'b1;
`ifdef AUD_CTRL_LOOP_EN
                        loop_pend  <= 1'b1;
`else
                        state      <= S_IDLE;
`endif
                    end else if (i_key_pause) begin
                        state       <= S_PLAY_PAUSE;
                        o_dsp_pause <= 1'b1;
                    end
                end
                S_PLAY_PAUSE: begin
                    if (i_key_stop) begin
                        state      <= S_IDLE;
                        o_dsp_stop <= 1'b1;
                    end else if (i_key_play) begin
                        state        <= S_PLAY;
                        o_dsp_start  <= 1'b1;
                        o_dsp_speed  <= i_speed;
                        o_dsp_fast   <= (mode_c == MODE_FAST);
                        o_dsp_slow_0 <= (mode_c == MODE_SLOW0);
                        o_dsp_slow_1 <= (mode_c == MODE_SLOW1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    aud_sec_timer #(
        .CLK_FREQ(CLK_FREQ)
    ) u_sec_timer (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_clr (time_clr_c),
        .i_en  (time_en_c),
        .o_sec (o_time_sec)
    );

endmodule

// File: tb/tb_aud_ctrl.sv
// Self-checking bench for aud_ctrl; command pulses are scoreboarded, status checked inline.
module tb_aud_ctrl;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REC   = 3'd1;
    localparam logic [2:0] ST_RECP  = 3'd2;
    localparam logic [2:0] ST_PLAY  = 3'd3;
    localparam logic [2:0] ST_PLAYP = 3'd4;

    // Command vector order: rec_start rec_pause rec_stop dsp_start dsp_pause dsp_stop
    localparam logic [5:0] C_REC_START = 6'b100000;
    localparam logic [5:0] C_REC_PAUSE = 6'b010000;
    localparam logic [5:0] C_REC_STOP  = 6'b001000;
    localparam logic [5:0] C_DSP_START = 6'b000100;
    localparam logic [5:0] C_DSP_PAUSE = 6'b000010;
    localparam logic [5:0] C_DSP_STOP  = 6'b000001;

    typedef struct packed {
        logic [5:0] cmd;
        logic [2:0] st;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_rec, key_play, key_pause, key_stop;
    logic [2:0]  speed;
    logic [1:0]  mode;
    logic [19:0] rec_addr, dsp_addr;
    logic        rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop;
    logic [2:0]  dsp_speed;
    logic        dsp_fast, dsp_slow_0, dsp_slow_1;
    logic [19:0] sram_addr, end_addr;
    logic        sram_we_n;
    logic [2:0]  state;
    logic [5:0]  time_sec;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    aud_ctrl #(.CLK_FREQ(4), .ADDR_MAX(20'hFFFFF)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_key_rec(key_rec), .i_key_play(key_play), .i_key_pause(key_pause), .i_key_stop(key_stop),
        .i_speed(speed), .i_mode(mode), .i_rec_addr(rec_addr), .i_dsp_addr(dsp_addr),
        .o_rec_start(rec_start), .o_rec_pause(rec_pause), .o_rec_stop(rec_stop),
        .o_dsp_start(dsp_start), .o_dsp_pause(dsp_pause), .o_dsp_stop(dsp_stop),
        .o_dsp_speed(dsp_speed), .o_dsp_fast(dsp_fast), .o_dsp_slow_0(dsp_slow_0),
        .o_dsp_slow_1(dsp_slow_1), .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n),
        .o_end_addr(end_addr), .o_state(state), .o_time_sec(time_sec)
    );

    // One clock; any command pulse seen must match the head of the scoreboard.
    task automatic tick();
        logic [5:0] obs;
        exp_t       e;
        @(posedge clk);
        #1;
        obs = {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop};
        if (obs != 6'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse cmd=%b state=%0d", obs, state);
            end else begin
                e = exp_q.pop_front();
                if (obs !== e.cmd || state !== e.st) begin
                    errors++;
                    $display("FAIL pulse cmd=%b state=%0d expected cmd=%b state=%0d", obs, state, e.cmd, e.st);
                end
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press(input logic r, input logic p, input logic pa, input logic s);
        key_rec = r; key_play = p; key_pause = pa; key_stop = s;
        tick();
        key_rec = 0; key_play = 0; key_pause = 0; key_stop = 0;
    endtask

    task automatic expect_pulse(input logic [5:0] cmd, input logic [2:0] st);
        exp_t e;
        e.cmd = cmd;
        e.st  = st;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_pulses=%0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1;
        ticks(2);
        rst = 0;
    endtask

    task automatic record_take(input logic [19:0] addr);
        rec_addr = 20'd0;
        expect_pulse(C_REC_START, ST_REC);
        press(1, 0, 0, 0);
        ticks(2);
        rec_addr = addr;
        expect_pulse(C_REC_STOP, ST_IDLE);
        press(0, 0, 0, 1);
    endtask

    task automatic test_reset();
        dsp_addr = 20'd123;
        rec_addr = 20'd55;
        rst = 1;
        key_rec = 1;
        ticks(2);
        key_rec = 0;
        rst = 0;
        chk("reset_state", 20'(state), 20'(ST_IDLE));
        chk("reset_end_addr", end_addr, 20'd0);
        chk("reset_time", 20'(time_sec), 20'd0);
        chk("reset_speed_mode", 20'({dsp_speed, dsp_fast, dsp_slow_0, dsp_slow_1}), 20'd0);
        chk("reset_we_n", 20'(sram_we_n), 20'd1);
        chk("reset_sram_addr", sram_addr, 20'd123);
        tick();
        chk("reset_key_ignored", 20'(state), 20'(ST_IDLE));
        drain("reset");
    endtask

    task automatic test_play_empty();
        press(0, 1, 0, 0);
        tick();
        chk("play_empty_state", 20'(state), 20'(ST_IDLE));
        drain("play_empty");
    endtask

    task automatic test_record_stop();
        rec_addr = 20'd20;
        expect_pulse(C_REC_START, ST_REC);
        press(1, 0, 0, 0);
        chk("rec_we_n", 20'(sram_we_n), 20'd0);
        chk("rec_sram_addr", sram_addr, 20'd20);
        ticks(5);
        rec_addr = 20'd37;
        expect_pulse(C_REC_STOP, ST_IDLE);
        press(0, 0, 0, 1);
        tick();
        chk("rec_end_addr", end_addr, 20'd37);
        chk("rec_stop_state", 20'(state), 20'(ST_IDLE));
        chk("idle_sram_addr", sram_addr, dsp_addr);
        drain("record_stop");
    endtask

    task automatic test_reset_mid_record();
        expect_pulse(C_REC_START, ST_REC);
        press(1, 0, 0, 0);
        ticks(3);
        rec_addr = 20'd55;
        do_reset();
        tick();
        chk("midrec_end_addr", end_addr, 20'd0);
        chk("midrec_state", 20'(state), 20'(ST_IDLE));
        drain("reset_mid_record");
    endtask

    task automatic test_play_end();
        record_take(20'd9);
        mode = 2'd3; speed = 3'd3; dsp_addr = 20'd0;
        expect_pulse(C_DSP_START, ST_PLAY);
        press(0, 1, 0, 0);
        chk("play_slow1", 20'({dsp_fast, dsp_slow_0, dsp_slow_1}), 20'b001);
        chk("play_speed", 20'(dsp_speed), 20'd3);
        for (int a = 1; a <= 9; a++) begin
            dsp_addr = 20'(a);
            tick();
        end
        chk("play_not_ended", 20'(state), 20'(ST_PLAY));
        dsp_addr = 20'd10;
`ifdef AUD_CTRL_LOOP_EN
        expect_pulse(C_DSP_STOP, ST_PLAY);
        tick();
        dsp_addr = 20'd0;
        expect_pulse(C_DSP_START, ST_PLAY);
        tick();
        chk("loop_time_clear", 20'(time_sec), 20'd0);
        chk("loop_state", 20'(state), 20'(ST_PLAY));
        expect_pulse(C_DSP_STOP, ST_IDLE);
        press(0, 0, 0, 1);
`else
        expect_pulse(C_DSP_STOP, ST_IDLE);
        tick();
`endif
        tick();
        chk("play_end_state", 20'(state), 20'(ST_IDLE));
        drain("play_end");
    endtask

    task automatic test_pause_resume();
        mode = 2'd0; speed = 3'd1; dsp_addr = 20'd2;
        expect_pulse(C_DSP_START, ST_PLAY);
        press(0, 1, 0, 0);
        speed = 3'd4; mode = 2'd1;
        ticks(2);
        chk("midplay_speed_held", 20'(dsp_speed), 20'd1);
        chk("midplay_fast_held", 20'(dsp_fast), 20'd0);
        expect_pulse(C_DSP_PAUSE, ST_PLAYP);
        press(0, 0, 1, 0);
        chk("pause_speed_held", 20'(dsp_speed), 20'd1);
        expect_pulse(C_DSP_START, ST_PLAY);
        press(0, 1, 0, 0);
        chk("resume_fast", 20'({dsp_fast, dsp_slow_0, dsp_slow_1}), 20'b100);
        chk("resume_speed", 20'(dsp_speed), 20'd4);
        drain("pause_resume");
    endtask

    task automatic test_simul_keys();
        expect_pulse(C_DSP_STOP, ST_IDLE);
        press(0, 0, 1, 1);
        tick();
        chk("simul_state", 20'(state), 20'(ST_IDLE));
        drain("simul_keys");
    endtask

    task automatic test_rec_overflow();
        rec_addr = 20'd100;
        expect_pulse(C_REC_START, ST_REC);
        press(1, 0, 0, 0);
        expect_pulse(C_REC_PAUSE, ST_RECP);
        press(1, 0, 1, 0);
        chk("recpause_we_n", 20'(sram_we_n), 20'd1);
        chk("recpause_sram_addr", sram_addr, 20'd100);
        expect_pulse(C_REC_START, ST_REC);
        press(1, 0, 0, 0);
        rec_addr = 20'hFFFFF;
        expect_pulse(C_REC_STOP, ST_IDLE);
        tick();
        rec_addr = 20'd0;
        tick();
        chk("overflow_end_addr", end_addr, 20'hFFFFF);
        chk("overflow_state", 20'(state), 20'(ST_IDLE));
        drain("rec_overflow");
    endtask

    task automatic test_timer();
        dsp_addr = 20'd0;
        expect_pulse(C_DSP_START, ST_PLAY);
        press(0, 1, 0, 0);
        chk("timer_start", 20'(time_sec), 20'd0);
        ticks(40);
        chk("timer_10s", 20'(time_sec), 20'd10);
        expect_pulse(C_DSP_PAUSE, ST_PLAYP);
        press(0, 0, 1, 0);
        ticks(20);
        chk("timer_pause_hold", 20'(time_sec), 20'd10);
        expect_pulse(C_DSP_START, ST_PLAY);
        press(0, 1, 0, 0);
        ticks(280);
        chk("timer_saturate", 20'(time_sec), 20'd63);
        expect_pulse(C_DSP_STOP, ST_IDLE);
        press(0, 0, 0, 1);
        ticks(8);
        chk("timer_idle_hold", 20'(time_sec), 20'd63);
        drain("timer");
    endtask

    initial begin
        rst = 1; key_rec = 0; key_play = 0; key_pause = 0; key_stop = 0;
        speed = 3'd0; mode = 2'd0; rec_addr = 20'd0; dsp_addr = 20'd0;
        test_reset();
        test_play_empty();
        test_record_stop();
        test_reset_mid_record();
        test_play_end();
        test_pause_resume();
        test_simul_keys();
        test_rec_overflow();
        test_timer();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
